// File: rtl/window_3x3_gen_if.sv
// window_3x3_gen_if: pixel stream in, 3x3 window stream out
interface window_3x3_gen_if #(parameter int DATA_WIDTH = 8);
   logic [DATA_WIDTH-1:0]      data_i;
   logic                       valid_i;
   logic                       sof_i;
   logic [8:0][DATA_WIDTH-1:0] data_o;
   logic                       valid_o;
   logic                       last_o;
   logic                       err_o;
   modport master (output data_i, valid_i, sof_i, input data_o, valid_o, last_o, err_o);
   modport slave (input data_i, valid_i, sof_i, output data_o, valid_o, last_o, err_o);
endinterface

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: raster pixel stream to fully populated 3x3 windows
module window_3x3_gen #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 320,
   parameter int IMG_HEIGHT = 240
) (
   input logic            clk,
   input logic            rst,
   window_3x3_gen_if.slave bus
);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   logic [CW-1:0]              col, cur_c;
   logic [RW-1:0]              row, cur_r;
   logic [DATA_WIDTH-1:0]      line0 [IMG_WIDTH];
   logic [DATA_WIDTH-1:0]      line1 [IMG_WIDTH];
   logic [8:0][DATA_WIDTH-1:0] win, win_n;
   logic                       eol, eof, emit, err;
   // sof forces the pixel to (0,0); window shifts left with the new column entering on the right
   always_comb begin
      cur_c    = bus.sof_i ? '0 : col;
      cur_r    = bus.sof_i ? '0 : row;
      eol      = cur_c == CW'(IMG_WIDTH - 1);
      eof      = cur_r == RW'(IMG_HEIGHT - 1);
      emit     = cur_r >= RW'(2) && cur_c >= CW'(2);
      err      = bus.sof_i && (col != '0 || row != '0);
      win_n[0] = win[1];
      win_n[1] = win[2];
      win_n[2] = line1[cur_c];
      win_n[3] = win[4];
      win_n[4] = win[5];
      win_n[5] = line0[cur_c];
      win_n[6] = win[7];
      win_n[7] = win[8];
      win_n[8] = bus.data_i;
   end
   // position counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         col         <= '0;
         row         <= '0;
         bus.data_o  <= '0;
         bus.valid_o <= 1'b0;
         bus.last_o  <= 1'b0;
         bus.err_o   <= 1'b0;
      end else begin
         bus.valid_o <= bus.valid_i && emit;
         bus.last_o  <= bus.valid_i && emit && eol && eof;
         bus.err_o   <= bus.valid_i && err;
         if (bus.valid_i) begin
            col <= eol ? '0 : cur_c + CW'(1);
            row <= eol ? (eof ? '0 : cur_r + RW'(1)) : cur_r;
            if (emit) bus.data_o <= win_n;
         end
      end
   end
   // line buffers and window shift register; contents are never cleared because counters gate the output
   always_ff @(posedge clk) begin
      if (bus.valid_i && !rst) begin
         line0[cur_c] <= bus.data_i;
         line1[cur_c] <= line0[cur_c];
         win          <= win_n;
      end
   end
endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen: directed checks of window_3x3_gen on a 5x4 image
module tb_window_3x3_gen;
   localparam int W = 5;
   localparam int H = 4;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          checks = 0;
   int          failures = 0;
   logic [71:0] held = '0;
   logic [71:0] f_first, f_last, g_first, g_last;
   window_3x3_gen_if #(.DATA_WIDTH(8)) bus ();
   window_3x3_gen #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic step(input logic [7:0] d, input logic v, input logic s);
      bus.data_i  = d;
      bus.valid_i = v;
      bus.sof_i   = s;
      @(posedge clk);
      #1;
   endtask
   function automatic logic [71:0] win_at(input logic [7:0] base, input int r, input int c);
      logic [71:0] w;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w[(i*3+j)*8 +: 8] = base + 8'((r - 2 + i) * 16 + c - 2 + j);
      return w;
   endfunction
   task automatic quiet(input string tag);
      chk({tag, "_valid"}, 72'(bus.valid_o), 72'd0);
      chk({tag, "_last"}, 72'(bus.last_o), 72'd0);
      chk({tag, "_err"}, 72'(bus.err_o), 72'd0);
      chk({tag, "_hold"}, bus.data_o, held);
   endtask
   task automatic partial(input int n);
      for (int k = 0; k < n; k++) begin
         step(8'((k / W) * 16 + k % W), 1'b1, k == 0);
         quiet("partial");
      end
   endtask
   task automatic run_frame(input logic [7:0] base, input logic gap, input logic err_first,
                            output logic [71:0] first_w, output logic [71:0] last_w);
      int wins = 0;
      int lasts = 0;
      first_w = '0;
      last_w  = '0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            logic v;
            v = r >= 2 && c >= 2;
            step(base + 8'(r * 16 + c), 1'b1, r == 0 && c == 0);
            chk("valid", 72'(bus.valid_o), 72'(v));
            chk("last", 72'(bus.last_o), 72'(r == H - 1 && c == W - 1));
            chk("err", 72'(bus.err_o), 72'(err_first && r == 0 && c == 0));
            if (v) begin
               held = win_at(base, r, c);
               if (wins == 0) first_w = bus.data_o;
               last_w = bus.data_o;
            end
            chk("data", bus.data_o, held);
            wins += int'(bus.valid_o);
            lasts += int'(bus.last_o);
            if (gap) begin
               step(8'hEE, 1'b0, 1'b1);
               quiet("gap");
            end
         end
      chk("win_count", 72'(wins), 72'd6);
      chk("last_count", 72'(lasts), 72'd1);
   endtask
   initial begin
      bus.data_i  = '0;
      bus.valid_i = 1'b0;
      bus.sof_i   = 1'b0;
      step(8'h00, 1'b0, 1'b0);
      step(8'h00, 1'b1, 1'b0);
      quiet("reset");
      rst = 1'b0;
      run_frame(8'h00, 1'b0, 1'b0, f_first, f_last);
      chk("t1_first", f_first, 72'h22_21_20_12_11_10_02_01_00);
      chk("t1_last", f_last, 72'h34_33_32_24_23_22_14_13_12);
      run_frame(8'h00, 1'b1, 1'b0, g_first, g_last);
      chk("t2_first", g_first, 72'h22_21_20_12_11_10_02_01_00);
      chk("t2_last", g_last, 72'h34_33_32_24_23_22_14_13_12);
      partial(7);
      rst = 1'b1;
      step(8'h55, 1'b1, 1'b0);
      held = '0;
      quiet("midreset");
      step(8'h66, 1'b1, 1'b1);
      quiet("midreset2");
      rst = 1'b0;
      run_frame(8'h00, 1'b0, 1'b0, g_first, g_last);
      chk("t3_first", g_first, 72'h22_21_20_12_11_10_02_01_00);
      chk("t3_last", g_last, 72'h34_33_32_24_23_22_14_13_12);
      partial(8);
      run_frame(8'h00, 1'b0, 1'b1, g_first, g_last);
      chk("t4_first", g_first, 72'h22_21_20_12_11_10_02_01_00);
      chk("t4_last", g_last, 72'h34_33_32_24_23_22_14_13_12);
      run_frame(8'h00, 1'b0, 1'b0, f_first, f_last);
      run_frame(8'h80, 1'b0, 1'b0, g_first, g_last);
      chk("t5_win1", f_first, 72'h22_21_20_12_11_10_02_01_00);
      chk("t5_win7", g_first, 72'hA2_A1_A0_92_91_90_82_81_80);
      chk("t5_win12", g_last, 72'hB4_B3_B2_A4_A3_A2_94_93_92);
      step(8'h00, 1'b0, 1'b0);
      quiet("idle");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
